// File: rtl/sbox_sub_engine.sv
// AES SubBytes engine: substitutes LANES bytes per cycle. The result appears N_BYTES/LANES cycles after accept.
// The result is held in DONE until out_ready. in_ready is high only in IDLE.
module sbox_sub_engine #(
   parameter int N_BYTES = 16,
   parameter int LANES   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_inv,
   input  logic [8*N_BYTES-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*N_BYTES-1:0] out_data,
   output logic                 busy
);
   localparam int N_STEPS = N_BYTES / LANES;
   localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // The inverse table is the forward table transposed at elaboration, so the two can never disagree.
   function automatic logic [2047:0] f_gen_inv();
      logic [2047:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) r[8*SBOX[i] +: 8] = i[7:0];
      return r;
   endfunction
   localparam logic [2047:0] INV_SBOX = f_gen_inv();

   state_t               r_state, w_next;
   logic [8*N_BYTES-1:0] r_work, r_out, w_sub_word;
   logic                 r_inv;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_accept, w_last;
   logic [7:0]           w_lane_in  [LANES];
   logic [7:0]           w_lane_out [LANES];

   assign w_last   = (r_cnt == CNT_W'(N_STEPS - 1));
   assign out_data = r_out;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      w_accept  = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_accept = 1'b1;
               w_next   = S_BUSY;
            end
         end
         S_BUSY: if (w_last) w_next = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_in[g]  = r_work[8*(int'(r_cnt)*LANES + g) +: 8];
      assign w_lane_out[g] = r_inv ? INV_SBOX[8*w_lane_in[g] +: 8] : SBOX[w_lane_in[g]];
   end

   always_comb begin
      w_sub_word = r_work;
      for (int l = 0; l < LANES; l++) w_sub_word[8*(int'(r_cnt)*LANES + l) +: 8] = w_lane_out[l];
   end

   // r_out is loaded only on the final BUSY step, so partial words never reach the output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_work <= '0;
         r_out  <= '0;
         r_inv  <= 1'b0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_work <= in_data;
         r_inv  <= in_inv;
         r_cnt  <= '0;
      end else if (r_state == S_BUSY) begin
         r_work <= w_sub_word;
         if (w_last) r_out <= w_sub_word;
         else        r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_sbox_sub_engine.sv
// Directed bench for sbox_sub_engine at LANES = 4, 1 and 16 against an arithmetic GF(2^8) S-box model.
module tb_sbox_sub_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         iv [3], ir [3], inv [3], ov [3], ordy [3], bsy [3];
   logic [127:0] id [3], od [3];
   localparam int LAT [3] = '{4, 16, 1};

   localparam logic [127:0] APPB_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] APPB_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

   sbox_sub_engine #(.N_BYTES(16), .LANES(4)) u_l4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_inv(inv[0]), .in_data(id[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]));
   sbox_sub_engine #(.N_BYTES(16), .LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_inv(inv[1]), .in_data(id[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]));
   sbox_sub_engine #(.N_BYTES(16), .LANES(16)) u_l16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_inv(inv[2]), .in_data(id[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bsy[2]));

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] ref_s [256];
   logic [7:0] ref_i [256];

   typedef struct {
      logic [127:0] din;
      logic         mode;
      logic [127:0] dout;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_math(input logic [7:0] x);
      logic [7:0] y;
      y = 8'h01;
      for (int i = 0; i < 254; i++) y = gmul(y, x);
      return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
   endfunction

   // Full transaction on instance k; caller is #1 after a rising edge with ordy[k]=1.
   task automatic run(input int k, input logic [127:0] din, input logic m,
                      input logic [127:0] exp, input string name);
      int cyc;
      check({name, " in_ready"}, ir[k], 1);
      iv[k] = 1'b1; id[k] = din; inv[k] = m;
      @(posedge clk); #1;
      iv[k] = 1'b0; id[k] = {4{$urandom}}; inv[k] = ~m;
      cyc = 0;
      while (!ov[k] && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, cyc, LAT[k]);
      check({name, " data"}, od[k], exp);
      @(posedge clk); #1;
      check({name, " out_valid drop"}, ov[k], 0);
   endtask

   task automatic sweep(input int k);
      logic [127:0] din, ef, ei;
      for (int w = 0; w < 16; w++) begin
         for (int j = 0; j < 16; j++) begin
            din[8*j +: 8] = 8'(16*w + j);
            ef[8*j +: 8]  = ref_s[16*w + j];
            ei[8*j +: 8]  = ref_i[16*w + j];
         end
         run(k, din, 1'b0, ef, $sformatf("sweep%0d fwd w%0d", k, w));
         run(k, din, 1'b1, ei, $sformatf("sweep%0d inv w%0d", k, w));
      end
   endtask

   task automatic thru(input int k);
      int t [3];
      int n = 0;
      int c = 0;
      t = '{0, 0, 0};
      iv[k] = 1'b1; inv[k] = 1'b0; id[k] = APPB_IN;
      while (n < 3 && c < 200) begin
         if (ir[k]) begin
            t[n] = c;
            n++;
         end
         @(posedge clk); #1;
         c++;
      end
      iv[k] = 1'b0;
      check($sformatf("thru%0d accepts", k), n, 3);
      check($sformatf("thru%0d period a", k), t[1] - t[0], LAT[k] + 2);
      check($sformatf("thru%0d period b", k), t[2] - t[1], LAT[k] + 2);
      c = 0;
      while (!ir[k] && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   initial begin
      for (int v = 0; v < 256; v++) ref_s[v] = sbox_math(8'(v));
      for (int v = 0; v < 256; v++) ref_i[ref_s[v]] = 8'(v);

      vecs[0] = '{APPB_IN,          1'b0, APPB_OUT};
      vecs[1] = '{APPB_OUT,         1'b1, APPB_IN};
      vecs[2] = '{{16{8'h63}},      1'b1, 128'h0};
      vecs[3] = '{128'h0,           1'b0, {16{8'h63}}};
      vecs[4] = '{{16{8'h53}},      1'b0, {16{8'hed}}};
      vecs[5] = '{{16{8'hff}},      1'b0, {16{8'h16}}};

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b1; inv[k] = 1'b0; id[k] = '1; ordy[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset%0d out_valid", k), ov[k], 0);
         check($sformatf("reset%0d out_data", k), od[k], 0);
         check($sformatf("reset%0d busy", k), bsy[k], 0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) iv[k] = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) check($sformatf("post-reset%0d in_ready", k), ir[k], 1);

      for (int i = 0; i < 6; i++) run(0, vecs[i].din, vecs[i].mode, vecs[i].dout, $sformatf("vec%0d", i));

      begin : backpressure
         int cyc;
         ordy[0] = 1'b0;
         iv[0] = 1'b1; id[0] = APPB_IN; inv[0] = 1'b0;
         @(posedge clk); #1;
         cyc = 0;
         while (!ov[0] && cyc < 40) begin
            id[0] = {4{$urandom}}; inv[0] = ~inv[0];
            @(posedge clk); #1;
            cyc++;
         end
         iv[0] = 1'b0;
         check("bp latency", cyc, 4);
         for (int i = 0; i < 10; i++) begin
            check($sformatf("bp hold valid %0d", i), ov[0], 1);
            check($sformatf("bp hold data %0d", i), od[0], APPB_OUT);
            check($sformatf("bp in_ready low %0d", i), ir[0], 0);
            id[0] = {4{$urandom}}; inv[0] = ~inv[0];
            @(posedge clk); #1;
         end
         ordy[0] = 1'b1;
         @(posedge clk); #1;
         check("bp release valid", ov[0], 0);
         check("bp release in_ready", ir[0], 1);
         check("bp release data kept", od[0], APPB_OUT);
      end

      begin : mid_reset
         iv[0] = 1'b1; id[0] = APPB_IN; inv[0] = 1'b0;
         @(posedge clk); #1;
         iv[0] = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b0;
         @(posedge clk); #1;
         check("midrst out_valid", ov[0], 0);
         check("midrst out_data", od[0], 0);
         check("midrst busy", bsy[0], 0);
         check("midrst in_ready", ir[0], 1);
         rst_n = 1'b1;
         @(posedge clk); #1;
         run(0, APPB_OUT, 1'b1, APPB_IN, "after midrst");
      end

      for (int k = 0; k < 3; k++) sweep(k);
      for (int k = 0; k < 3; k++) thru(k);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
